// File: rtl/median_pkg.sv
// Shared definitions for the median filter datapath: default pixel width and
// the line-fill state encoding used by the line buffer.
package median_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } fill_state_t;

endpackage

// File: rtl/line_ram.sv
// Single-port line RAM, read-first: rdata shows the pre-write word at addr, and the
// write lands on the clock edge. The owner's output register provides the read latency.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/line_buf_3row.sv
// Three-row line buffer: emits (row N-2, row N-1, row N) per accepted pixel, 1-cycle latency.
// Build option LINE_BUF_PAD_EN enables border replication during the first two lines.
module line_buf_3row
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 640,
  parameter int COL_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  frame_start,
  input  logic                  pix_in_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [DATA_WIDTH-1:0] data0_out,
  output logic [DATA_WIDTH-1:0] data1_out,
  output logic [DATA_WIDTH-1:0] data2_out,
  output logic                  data_out_valid
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  fill_state_t           state, state_nxt, state_eff;
  logic [COL_W-1:0]      col, col_nxt, col_eff;
  logic                  last_col;
  logic [DATA_WIDTH-1:0] l1_rd, l2_rd;

  // frame_start overrides the stored position for this cycle's pixel, so a
  // coincident last-column pixel never advances the state.
  always_comb begin
    state_eff = frame_start ? FILL0 : state;
    col_eff   = frame_start ? '0 : col;
    last_col  = (col_eff == LAST_COL);
    state_nxt = state_eff;
    col_nxt   = col_eff;
    if (pix_in_valid) begin
      if (last_col) begin
        col_nxt = '0;
        case (state_eff)
          FILL0:   state_nxt = FILL1;
          default: state_nxt = RUN;
        endcase
      end else begin
        col_nxt = col_eff + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state <= FILL0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
    end
  end

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(COL_W)) u_l1 (
    .clk   (clk),
    .we    (pix_in_valid),
    .addr  (col_eff),
    .wdata (pix_in),
    .rdata (l1_rd)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(COL_W)) u_l2 (
    .clk   (clk),
    .we    (pix_in_valid),
    .addr  (col_eff),
    .wdata (l1_rd),
    .rdata (l2_rd)
  );

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      data0_out      <= '0;
      data1_out      <= '0;
      data2_out      <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
`ifdef LINE_BUF_PAD_EN
      if (pix_in_valid) begin
        data_out_valid <= 1'b1;
        data2_out      <= pix_in;
        case (state_eff)
          FILL0: begin
            data0_out <= pix_in;
            data1_out <= pix_in;
          end
          FILL1: begin
            data0_out <= l1_rd;
            data1_out <= l1_rd;
          end
          default: begin
            data0_out <= l2_rd;
            data1_out <= l1_rd;
          end
        endcase
      end
`else
      if (pix_in_valid && (state_eff == RUN)) begin
        data_out_valid <= 1'b1;
        data0_out      <= l2_rd;
        data1_out      <= l1_rd;
        data2_out      <= pix_in;
      end
`endif
    end
  end

endmodule

// File: tb/tb_line_buf_3row.sv
// Directed bench for line_buf_3row with IMG_WIDTH=4; expectations follow LINE_BUF_PAD_EN.
module tb_line_buf_3row;

  localparam int W = 4;
`ifdef LINE_BUF_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       frame_start = 1'b0;
  logic       pix_in_valid = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic [7:0] data0_out, data1_out, data2_out;
  logic       data_out_valid;

  int checks = 0;
  int errors = 0;

  logic       ov;
  logic [7:0] o0, o1, o2;
  logic [7:0] frm [0:31];

  line_buf_3row #(.DATA_WIDTH(8), .IMG_WIDTH(W), .COL_W(2)) dut (
    .clk            (clk),
    .reset_p        (reset_p),
    .frame_start    (frame_start),
    .pix_in_valid   (pix_in_valid),
    .pix_in         (pix_in),
    .data0_out      (data0_out),
    .data1_out      (data1_out),
    .data2_out      (data2_out),
    .data_out_valid (data_out_valid)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; captures the outputs just after the next rising edge.
  task automatic step(input logic fs, input logic v, input logic [7:0] d);
    frame_start  = fs;
    pix_in_valid = v;
    pix_in       = d;
    @(posedge clk);
    #1;
    ov = data_out_valid;
    o0 = data0_out;
    o1 = data1_out;
    o2 = data2_out;
    @(negedge clk);
    frame_start  = 1'b0;
    pix_in_valid = 1'b0;
  endtask

  // Expected {valid, d0, d1, d2} for the k-th pixel (0-based) of a frame held in frm.
  function automatic logic [24:0] exp_at(input int k);
    logic [7:0] a, b, c;
    logic       v;
    c = frm[k];
    if (k < W) begin
      a = frm[k]; b = frm[k];
    end else if (k < 2 * W) begin
      a = frm[k - W]; b = frm[k - W];
    end else begin
      a = frm[k - 2 * W]; b = frm[k - W];
    end
    v = PAD ? 1'b1 : (k >= 2 * W);
    return {v, a, b, c};
  endfunction

  task automatic test_reset();
    logic [24:0] e;
    checks++;
    if ({data_out_valid, data0_out, data1_out, data2_out} !== 25'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b %h %h %h, want all 0",
               data_out_valid, data0_out, data1_out, data2_out);
    end
    @(negedge clk);
    reset_p = 1'b0;
    for (int i = 0; i < 12; i++) step(i == 0, 1'b1, 8'(i + 1));
    // outputs now hold (4,8,12) valid; reset must clear them without a clock edge
    #2;
    reset_p = 1'b1;
    #1;
    checks++;
    if ({data_out_valid, data0_out, data1_out, data2_out} !== 25'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%0b %h %h %h, want all 0",
               data_out_valid, data0_out, data1_out, data2_out);
    end
    @(negedge clk);
    reset_p = 1'b0;
    for (int i = 0; i < 12; i++) frm[i] = 8'(i + 1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, frm[i]);
      e = exp_at(i);
      checks++;
      if (ov !== e[24] || (e[24] && {o0, o1, o2} !== e[23:0])) begin
        errors++;
        $display("FAIL reset_refill[%0d]: got v=%0b %h %h %h, want v=%0b %h %h %h",
                 i, ov, o0, o1, o2, e[24], e[23:16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_fill();
    logic [24:0] e;
    for (int i = 0; i < 12; i++) frm[i] = 8'(i + 1);
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 1'b1, frm[i]);
      e = exp_at(i);
      checks++;
      if (ov !== e[24] || (e[24] && {o0, o1, o2} !== e[23:0])) begin
        errors++;
        $display("FAIL fill[%0d]: got v=%0b %h %h %h, want v=%0b %h %h %h",
                 i, ov, o0, o1, o2, e[24], e[23:16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [24:0] e;
    for (int i = 0; i < 12; i++) frm[i] = 8'h40 + 8'(i);
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 1'b1, frm[i]);
      e = exp_at(i);
      checks++;
      if (ov !== e[24] || (e[24] && {o0, o1, o2} !== e[23:0])) begin
        errors++;
        $display("FAIL gaps[%0d]: got v=%0b %h %h %h, want v=%0b %h %h %h",
                 i, ov, o0, o1, o2, e[24], e[23:16], e[15:8], e[7:0]);
      end
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 8'hFF);
        checks++;
        if (ov !== 1'b0) begin
          errors++;
          $display("FAIL gap_valid[%0d.%0d]: got %0b, want 0", i, g, ov);
        end
      end
    end
  endtask

  task automatic test_fs_idle();
    logic [24:0] e;
    for (int i = 0; i < 5; i++) step(i == 0, 1'b1, 8'hEE);
    step(1'b1, 1'b0, 8'h00);
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL fs_idle_valid: got %0b, want 0", ov);
    end
    for (int i = 0; i < 12; i++) frm[i] = 8'h60 + 8'(i);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, frm[i]);
      e = exp_at(i);
      checks++;
      if (ov !== e[24] || (e[24] && {o0, o1, o2} !== e[23:0])) begin
        errors++;
        $display("FAIL fs_idle[%0d]: got v=%0b %h %h %h, want v=%0b %h %h %h",
                 i, ov, o0, o1, o2, e[24], e[23:16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_last_col_fs();
    logic [24:0] e;
    // 7 pixels leave col=3 in FILL1; the frame_start pixel lands on the last column
    for (int i = 0; i < 7; i++) step(i == 0, 1'b1, 8'h30 + 8'(i));
    for (int i = 0; i < 12; i++) frm[i] = 8'h80 + 8'(i);
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 1'b1, frm[i]);
      e = exp_at(i);
      checks++;
      if (ov !== e[24] || (e[24] && {o0, o1, o2} !== e[23:0])) begin
        errors++;
        $display("FAIL last_col_fs[%0d]: got v=%0b %h %h %h, want v=%0b %h %h %h",
                 i, ov, o0, o1, o2, e[24], e[23:16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_midline();
    logic [24:0] e;
    for (int i = 0; i < 6; i++) step(i == 0, 1'b1, 8'h10 + 8'(i));
    frm[0] = 8'hA0;
    for (int i = 1; i < 12; i++) frm[i] = 8'hB0 + 8'(i);
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 1'b1, frm[i]);
      e = exp_at(i);
      checks++;
      if (ov !== e[24] || (e[24] && {o0, o1, o2} !== e[23:0])) begin
        errors++;
        $display("FAIL midline[%0d]: got v=%0b %h %h %h, want v=%0b %h %h %h",
                 i, ov, o0, o1, o2, e[24], e[23:16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_long_run();
    logic [7:0] ea, eb, ec;
    logic       ev;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < W; c++) begin
        step(r == 0 && c == 0, 1'b1, 8'(r * 16 + c));
        ec = 8'(r * 16 + c);
        if (r == 0) begin
          ea = ec; eb = ec; ev = PAD;
        end else if (r == 1) begin
          ea = 8'(c); eb = 8'(c); ev = PAD;
        end else begin
          ea = 8'((r - 2) * 16 + c); eb = 8'((r - 1) * 16 + c); ev = 1'b1;
        end
        checks++;
        if (ov !== ev || (ev && {o0, o1, o2} !== {ea, eb, ec})) begin
          errors++;
          $display("FAIL long_run[r%0d c%0d]: got v=%0b %h %h %h, want v=%0b %h %h %h",
                   r, c, ov, o0, o1, o2, ev, ea, eb, ec);
        end
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_fill();
    test_gaps();
    test_fs_idle();
    test_last_col_fs();
    test_midline();
    test_long_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
